// File: rtl/predictor_scheduler.sv
// Shared table of 2-bit saturating branch counters. Two round-robin lookup ports and one
// update stream share one table op per cycle; updates queue in an in-order FIFO.
module predictor_scheduler #(
  parameter int IDX_W     = 4,
  parameter int UPD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [IDX_W-1:0] idx0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [IDX_W-1:0] idx1,
  output logic             gnt1,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic             prediction
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CNT_W   = $clog2(UPD_DEPTH + 1);

  logic [1:0]       ctr        [ENTRIES];
  logic [IDX_W-1:0] fifo_idx   [UPD_DEPTH];
  logic             fifo_taken [UPD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rr_last;

  logic             full, any_req, grant, push, pop;
  logic [IDX_W-1:0] lk_idx, head_idx;
  logic             head_taken;
  logic [1:0]       head_val, next_val;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(UPD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(UPD_DEPTH));
  assign any_req   = req0 | req1;
  assign upd_ready = !full;

  // A full FIFO steals the cycle from lookups; otherwise lookups beat idle-cycle drains.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !full) begin
      if (req0 && req1) begin
        gnt0 = rr_last;
        gnt1 = !rr_last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign grant  = gnt0 | gnt1;
  assign lk_idx = gnt1 ? idx1 : idx0;
  assign push   = !reset && upd_valid && upd_ready;
  assign pop    = !reset && (full || (!any_req && (count != '0)));

  assign head_idx   = fifo_idx[rd_ptr];
  assign head_taken = fifo_taken[rd_ptr];
  assign head_val   = ctr[head_idx];

  always_comb begin
    next_val = head_val;
    if (head_taken) begin
      if (head_val != 2'b11) next_val = head_val + 2'd1;
    end else begin
      if (head_val != 2'b00) next_val = head_val - 2'd1;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= upd_index;
      fifo_taken[wr_ptr] <= upd_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_last    <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      prediction <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        ctr[head_idx] <= next_val;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      resp_valid <= grant;
      if (grant) begin
        resp_id    <= gnt1;
        prediction <= ctr[lk_idx][1];
        rr_last    <= gnt1;
      end
    end
  end

endmodule

// File: tb/tb_predictor_scheduler.sv
// Directed bench for predictor_scheduler: expected responses are queued when a lookup is
// granted and checked by an independent monitor when resp_valid appears.
module tb_predictor_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [3:0] idx0, idx1;
  logic       gnt0, gnt1;
  logic       upd_valid;
  logic [3:0] upd_index;
  logic       upd_taken;
  logic       upd_ready;
  logic       resp_valid, resp_id, prediction;

  // Expected prediction for whatever each port is currently requesting.
  logic exp_p0, exp_p1;

  logic [1:0] exp_q[$];  // {resp_id, prediction}
  int pass_cnt  = 0;
  int total_cnt = 0;

  predictor_scheduler #(.IDX_W(4), .UPD_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .idx0(idx0), .gnt0(gnt0),
    .req1(req1), .idx1(idx1), .gnt1(gnt1),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .prediction(prediction)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard push: a granted lookup owes a response next cycle.
  always @(negedge clk) begin
    if (gnt0 === 1'b1) exp_q.push_back({1'b0, exp_p0});
    if (gnt1 === 1'b1) exp_q.push_back({1'b1, exp_p1});
  end

  // Monitor
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      logic [1:0] e;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected: got id=%0d pred=%0d with nothing expected", resp_id, prediction);
      end else begin
        e = exp_q.pop_front();
        if ({resp_id, prediction} === e) pass_cnt++;
        else $display("FAIL resp: got id=%0d pred=%0d expected id=%0d pred=%0d",
                      resp_id, prediction, e[1], e[0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic lookup(input bit port, input logic [3:0] idx, input bit pred);
    bit got;
    got = 1'b0;
    if (port) begin req1 = 1'b1; idx1 = idx; exp_p1 = pred; end
    else      begin req0 = 1'b1; idx0 = idx; exp_p0 = pred; end
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      got = port ? gnt1 : gnt0;
      tick();
    end
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    check("lookup_grant_within_bound", got, 1'b1);
  endtask

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; idx0 = 0; idx1 = 0;
    upd_valid = 0; upd_index = 0; upd_taken = 0; exp_p0 = 0; exp_p1 = 0;
    do_reset();

    // Reset state
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_prediction", prediction, 0);
    check("rst_upd_ready", upd_ready, 1);
    check("rst_gnt", {gnt0, gnt1}, 2'b00);

    // 1: single lookup, same-cycle grant, response next cycle
    tick();
    req0 = 1; idx0 = 3; exp_p0 = 0;
    #1 check("t1_gnt0", {gnt0, gnt1}, 2'b10);
    tick();
    req0 = 0;
    #1 check("t1_resp_valid", resp_valid, 1);

    // 2: idle drains, saturation and decrement on idx 5
    tick();
    upd_valid = 1; upd_index = 5; upd_taken = 1;
    #1 check("t2_upd_ready", upd_ready, 1);
    tick();
    tick();
    upd_valid = 0;
    tick(); tick();
    lookup(0, 5, 1);                 // counter 2
    upd_valid = 1; upd_taken = 1;
    tick(); tick();                  // 3, stays 3
    upd_taken = 0;
    tick(); tick();                  // 2, 1
    upd_valid = 0;
    tick(); tick(); tick();
    lookup(1, 5, 0);                 // counter 1

    // 3: both ports held from reset alternate 0,1,0,1
    req0 = 1; idx0 = 1; req1 = 1; idx1 = 2; exp_p0 = 0; exp_p1 = 0;
    reset = 1;
    tick();
    #1 check("t3_gnt_in_reset", {gnt0, gnt1}, 2'b00);
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("t3_gnt_alternate", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req0 = 0; req1 = 0;
    tick();

    // 4: full FIFO forces an update and blocks both grants for one cycle
    req0 = 1; req1 = 1;
    do_reset();
    upd_index = 7; upd_taken = 1;
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1;
      #1 check("t4_gnt_alternate", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("t4_upd_ready_filling", upd_ready, 1);
      tick();
    end
    upd_valid = 0;
    #1 check("t4_upd_ready_full", upd_ready, 0);
    check("t4_forced_no_gnt", {gnt0, gnt1}, 2'b00);
    tick();
    #1 check("t4_upd_ready_after_force", upd_ready, 1);
    check("t4_resp_valid_after_force", resp_valid, 0);
    check("t4_gnt_resume", {gnt0, gnt1}, 2'b10);
    tick();
    req0 = 0; req1 = 0;
    tick(); tick(); tick(); tick();
    lookup(0, 7, 1);                 // 4 taken -> 3

    // 5: push+pop at count 2 keeps count; order N,N,T,T,T on idx 9 -> 3
    do_reset();
    req0 = 1; idx0 = 0; exp_p0 = 0;
    upd_valid = 1; upd_index = 9; upd_taken = 0;
    tick(); tick();                  // count 2
    req0 = 0; upd_taken = 1;
    #1 check("t5_drain_no_gnt", gnt0, 0);
    tick();                          // pop+push
    req0 = 1;
    tick();                          // count 3
    #1 check("t5_upd_ready_count3", upd_ready, 1);
    tick();                          // count 4
    upd_valid = 0; req0 = 0;
    #1 check("t5_upd_ready_full", upd_ready, 0);
    for (int i = 0; i < 6; i++) tick();
    lookup(0, 9, 1);

    // 6: reset with count 3 and a response in flight
    req0 = 1; idx0 = 0; exp_p0 = 0;
    upd_valid = 1; upd_index = 4; upd_taken = 1;
    tick(); tick(); tick();
    reset = 1; req0 = 0; upd_valid = 0;
    tick();
    reset = 0;
    #1 check("t6_resp_valid_dropped", resp_valid, 0);
    check("t6_upd_ready", upd_ready, 1);
    tick();
    lookup(0, 9, 0);                 // table cleared
    tick(); tick(); tick(); tick();
    lookup(1, 4, 0);                 // FIFO flushed, nothing drained

    tick(); tick(); tick();
    check("resp_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
